// File: rtl/pe_pkg.sv
// Shared command encoding, control-state type and sizing helper for the PE router cell.
package pe_pkg;

    typedef enum logic [2:0] {
        CmdMac        = 3'b000,
        CmdShiftUp    = 3'b001,
        CmdShiftDown  = 3'b010,
        CmdShiftLeft  = 3'b011,
        CmdShiftRight = 3'b100,
        CmdLoadImage  = 3'b101,
        CmdLoadAcc    = 3'b110,
        CmdClear      = 3'b111
    } pe_cmd_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StDone = 2'b10
    } pe_state_e;

    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pe_mac_pipe.sv
// Signed multiplier with a MAC_LATENCY-deep register pipeline; valid travels alongside the product.
module pe_mac_pipe #(
    parameter int unsigned PRECISION   = 8,
    parameter int unsigned MAC_LATENCY = 2
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_valid,
    input  logic signed [PRECISION-1:0]   i_a,
    input  logic signed [PRECISION-1:0]   i_b,
    output logic                          o_valid,
    output logic signed [2*PRECISION-1:0] o_prod
);

    localparam int unsigned PW = 2 * PRECISION;

    logic signed [PW-1:0] r_prod  [MAC_LATENCY];
    logic                 r_valid [MAC_LATENCY];
    logic signed [PW-1:0] w_prod;

    // Operands are widened before the multiply so the full signed product is kept.
    assign w_prod = PW'(i_a) * PW'(i_b);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < MAC_LATENCY; k++) begin
                r_valid[k] <= 1'b0;
                r_prod[k]  <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_prod[0]  <= w_prod;
            for (int k = 1; k < MAC_LATENCY; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_prod[k]  <= r_prod[k-1];
            end
        end
    end

    assign o_valid = r_valid[MAC_LATENCY-1];
    assign o_prod  = r_prod[MAC_LATENCY-1];

endmodule

// File: rtl/pe_router_cell.sv
// Processing-element cell: image registers with neighbour shifting, a pipelined MAC into a
// signed accumulator, and an IDLE/EXEC/DONE handshake with done held until acknowledged.
module pe_router_cell
    import pe_pkg::*;
#(
    parameter int unsigned PRECISION        = 8,
    parameter int unsigned OUTPUT_PRECISION = 32,
    parameter int unsigned NUM_IMAGES       = 2,
    parameter int unsigned MAC_LATENCY      = 2,
    parameter int unsigned SATURATE         = 0,
    localparam int unsigned SEL_W           = sel_width(NUM_IMAGES)
) (
    input  logic                             CLK,
    input  logic                             reset,
    input  logic                             start,
    input  logic [2:0]                       cmd,
    input  logic [SEL_W-1:0]                 image_sel,
    input  logic [SEL_W-1:0]                 a_sel,
    input  logic [SEL_W-1:0]                 b_sel,
    input  logic [PRECISION-1:0]             isu,
    input  logic [PRECISION-1:0]             isd,
    input  logic [PRECISION-1:0]             isl,
    input  logic [PRECISION-1:0]             isr,
    output logic [PRECISION-1:0]             osu,
    output logic [PRECISION-1:0]             osd,
    output logic [PRECISION-1:0]             osl,
    output logic [PRECISION-1:0]             osr,
    input  logic [PRECISION-1:0]             load_data,
    input  logic [OUTPUT_PRECISION-1:0]      acc_load,
    input  logic                             ack,
    output logic                             busy,
    output logic                             done,
    output logic [OUTPUT_PRECISION-1:0]      acc,
    output logic                             overflow,
    output logic [NUM_IMAGES*PRECISION-1:0]  image_bus
);

    localparam logic [SEL_W:0] NUM_IMG_W = (SEL_W + 1)'(NUM_IMAGES);
    localparam int unsigned    OPW       = OUTPUT_PRECISION;

    pe_state_e                     r_state;
    logic [PRECISION-1:0]          r_image [NUM_IMAGES];
    logic [PRECISION-1:0]          r_osu, r_osd, r_osl, r_osr;
    logic signed [OPW-1:0]         r_acc;
    logic                          r_overflow;

    pe_cmd_e                       w_cmd;
    logic [SEL_W-1:0]              w_img_idx, w_a_idx, w_b_idx;
    logic                          w_mac_start, w_mac_valid;
    logic signed [PRECISION-1:0]   w_op_a, w_op_b;
    logic signed [2*PRECISION-1:0] w_prod;
    logic signed [OPW-1:0]         w_prod_ext, w_sum, w_sat, w_acc_next;
    logic                          w_ovf;

    // Indices past the last image register fall back to image 0.
    function automatic logic [SEL_W-1:0] fix_sel(input logic [SEL_W-1:0] sel);
        return ({1'b0, sel} < NUM_IMG_W) ? sel : '0;
    endfunction

    assign w_cmd       = pe_cmd_e'(cmd);
    assign w_img_idx   = fix_sel(image_sel);
    assign w_a_idx     = fix_sel(a_sel);
    assign w_b_idx     = fix_sel(b_sel);
    assign w_mac_start = (r_state == StIdle) && start && (w_cmd == CmdMac);
    assign w_op_a      = r_image[w_a_idx];
    assign w_op_b      = r_image[w_b_idx];

    pe_mac_pipe #(
        .PRECISION   (PRECISION),
        .MAC_LATENCY (MAC_LATENCY)
    ) u_mac_pipe (
        .i_clk   (CLK),
        .i_reset (reset),
        .i_valid (w_mac_start),
        .i_a     (w_op_a),
        .i_b     (w_op_b),
        .o_valid (w_mac_valid),
        .o_prod  (w_prod)
    );

    // Overflow: both addends share a sign that the wrapped sum does not.
    assign w_prod_ext = OPW'(w_prod);
    assign w_sum      = r_acc + w_prod_ext;
    assign w_ovf      = (r_acc[OPW-1] == w_prod_ext[OPW-1]) && (w_sum[OPW-1] != r_acc[OPW-1]);
    assign w_sat      = w_prod_ext[OPW-1] ? {1'b1, {(OPW-1){1'b0}}} : {1'b0, {(OPW-1){1'b1}}};
    assign w_acc_next = ((SATURATE != 0) && w_ovf) ? w_sat : w_sum;

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state    <= StIdle;
            r_acc      <= '0;
            r_overflow <= 1'b0;
            r_osu      <= '0;
            r_osd      <= '0;
            r_osl      <= '0;
            r_osr      <= '0;
            for (int k = 0; k < NUM_IMAGES; k++) r_image[k] <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_state <= StDone;
                        unique case (w_cmd)
                            CmdMac: r_state <= StExec;
                            CmdShiftUp: begin
                                r_osu              <= r_image[w_img_idx];
                                r_image[w_img_idx] <= isu;
                            end
                            CmdShiftDown: begin
                                r_osd              <= r_image[w_img_idx];
                                r_image[w_img_idx] <= isd;
                            end
                            CmdShiftLeft: begin
                                r_osl              <= r_image[w_img_idx];
                                r_image[w_img_idx] <= isl;
                            end
                            CmdShiftRight: begin
                                r_osr              <= r_image[w_img_idx];
                                r_image[w_img_idx] <= isr;
                            end
                            CmdLoadImage: r_image[w_img_idx] <= load_data;
                            CmdLoadAcc: begin
                                r_acc      <= acc_load;
                                r_overflow <= 1'b0;
                            end
                            CmdClear: begin
                                r_acc      <= '0;
                                r_overflow <= 1'b0;
                                r_osu      <= '0;
                                r_osd      <= '0;
                                r_osl      <= '0;
                                r_osr      <= '0;
                                for (int k = 0; k < NUM_IMAGES; k++) r_image[k] <= '0;
                            end
                            default: r_state <= StDone;
                        endcase
                    end
                end
                StExec: begin
                    if (w_mac_valid) begin
                        r_acc      <= w_acc_next;
                        r_overflow <= r_overflow | w_ovf;
                        r_state    <= StDone;
                    end
                end
                StDone: begin
                    if (ack) r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_comb begin
        image_bus = '0;
        for (int k = 0; k < NUM_IMAGES; k++) image_bus[k*PRECISION +: PRECISION] = r_image[k];
    end

    assign busy     = (r_state != StIdle);
    assign done     = (r_state == StDone);
    assign acc      = r_acc;
    assign overflow = r_overflow;
    assign osu      = r_osu;
    assign osd      = r_osd;
    assign osl      = r_osl;
    assign osr      = r_osr;

endmodule

// File: tb/tb_pe_router_cell.sv
// Directed bench: a saturating and a wrapping 16-bit cell driven by identical stimulus.
module tb_pe_router_cell;
    import pe_pkg::*;

    localparam int unsigned P   = 8;
    localparam int unsigned OP  = 16;
    localparam int unsigned NI  = 3;
    localparam int unsigned SW  = 2;
    localparam int unsigned LAT = 2;

    logic           CLK = 1'b0;
    logic           reset, start, ack;
    logic [2:0]     cmd;
    logic [SW-1:0]  image_sel, a_sel, b_sel;
    logic [P-1:0]   isu, isd, isl, isr, load_data;
    logic [OP-1:0]  acc_load;

    logic           sat_busy, sat_done, sat_ovf, wrp_busy, wrp_done, wrp_ovf;
    logic [OP-1:0]  sat_acc, wrp_acc;
    logic [P-1:0]   sat_osu, sat_osd, sat_osl, sat_osr, wrp_osu, wrp_osd, wrp_osl, wrp_osr;
    logic [NI*P-1:0] sat_bus, wrp_bus;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    pe_router_cell #(
        .PRECISION (P), .OUTPUT_PRECISION (OP), .NUM_IMAGES (NI),
        .MAC_LATENCY (LAT), .SATURATE (1)
    ) dut_sat (
        .CLK (CLK), .reset (reset), .start (start), .cmd (cmd), .image_sel (image_sel),
        .a_sel (a_sel), .b_sel (b_sel), .isu (isu), .isd (isd), .isl (isl), .isr (isr),
        .osu (sat_osu), .osd (sat_osd), .osl (sat_osl), .osr (sat_osr),
        .load_data (load_data), .acc_load (acc_load), .ack (ack), .busy (sat_busy),
        .done (sat_done), .acc (sat_acc), .overflow (sat_ovf), .image_bus (sat_bus)
    );

    pe_router_cell #(
        .PRECISION (P), .OUTPUT_PRECISION (OP), .NUM_IMAGES (NI),
        .MAC_LATENCY (LAT), .SATURATE (0)
    ) dut_wrp (
        .CLK (CLK), .reset (reset), .start (start), .cmd (cmd), .image_sel (image_sel),
        .a_sel (a_sel), .b_sel (b_sel), .isu (isu), .isd (isd), .isl (isl), .isr (isr),
        .osu (wrp_osu), .osd (wrp_osd), .osl (wrp_osl), .osr (wrp_osr),
        .load_data (load_data), .acc_load (acc_load), .ack (ack), .busy (wrp_busy),
        .done (wrp_done), .acc (wrp_acc), .overflow (wrp_ovf), .image_bus (wrp_bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check2(input string tag, input logic [31:0] obs_s, input logic [31:0] obs_w,
                          input logic [31:0] exp);
        check({"sat_", tag}, obs_s, exp);
        check({"wrp_", tag}, obs_w, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic go(input logic [2:0] c, input logic [SW-1:0] sel, input logic [SW-1:0] as,
                      input logic [SW-1:0] bs);
        cmd       = c;
        image_sel = sel;
        a_sel     = as;
        b_sel     = bs;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic load_img(input logic [SW-1:0] sel, input logic [P-1:0] d);
        load_data = d;
        go(CmdLoadImage, sel, 2'd0, 2'd0);
        do_ack();
    endtask

    task automatic load_acc(input logic [OP-1:0] v);
        acc_load = v;
        go(CmdLoadAcc, 2'd0, 2'd0, 2'd0);
        do_ack();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; ack = 1'b0; cmd = '0;
        image_sel = '0; a_sel = '0; b_sel = '0;
        isu = '0; isd = '0; isl = '0; isr = '0; load_data = '0; acc_load = '0;
        tick();
        tick();
        reset = 1'b0;
        check2("rst_busy", sat_busy, wrp_busy, 0);
        check2("rst_done", sat_done, wrp_done, 0);
        check2("rst_acc", sat_acc, wrp_acc, 0);
        check2("rst_ovf", sat_ovf, wrp_ovf, 0);
        check2("rst_bus", sat_bus, wrp_bus, 0);

        // Load latency is one edge; done holds until ack.
        load_data = 8'hFD;
        go(CmdLoadImage, 2'd0, 2'd0, 2'd0);
        check2("ldimg_done", sat_done, wrp_done, 1);
        check2("ldimg_busy", sat_busy, wrp_busy, 1);
        do_ack();
        check2("ack_done", sat_done, wrp_done, 0);
        check2("ack_busy", sat_busy, wrp_busy, 0);
        load_img(2'd1, 8'h07);
        load_acc(16'd100);
        check2("ldacc", sat_acc, wrp_acc, 16'd100);
        check2("bus_a", sat_bus, wrp_bus, 24'h0007FD);

        // MAC -3*7 onto 100, with a clear pulsed during EXEC that must be ignored.
        go(CmdMac, 2'd0, 2'd0, 2'd1);
        check2("mac_e0_done", sat_done, wrp_done, 0);
        check2("mac_e0_busy", sat_busy, wrp_busy, 1);
        cmd   = CmdClear;
        start = 1'b1;
        tick();
        start = 1'b0;
        check2("mac_e1_done", sat_done, wrp_done, 0);
        check2("mac_e1_acc", sat_acc, wrp_acc, 16'd100);
        tick();
        check2("mac_e2_done", sat_done, wrp_done, 1);
        check2("mac_acc", sat_acc, wrp_acc, 16'd79);
        check2("mac_ovf", sat_ovf, wrp_ovf, 0);
        check2("mac_bus", sat_bus, wrp_bus, 24'h0007FD);

        // Start in DONE ignored; done held while ack low; ack+start returns to IDLE only.
        load_data = 8'h55;
        go(CmdLoadImage, 2'd0, 2'd0, 2'd0);
        check2("done_start_bus", sat_bus, wrp_bus, 24'h0007FD);
        for (int i = 0; i < 5; i++) begin
            tick();
            check2("done_hold", sat_done, wrp_done, 1);
        end
        ack   = 1'b1;
        start = 1'b1;
        tick();
        ack   = 1'b0;
        start = 1'b0;
        check2("ackstart_done", sat_done, wrp_done, 0);
        check2("ackstart_busy", sat_busy, wrp_busy, 0);
        tick();
        check2("ackstart_bus", sat_bus, wrp_bus, 24'h0007FD);
        check2("ackstart_idle", sat_busy, wrp_busy, 0);

        // Shifts: build up osu/osd/osr on image 1, then shift left on image 0.
        load_img(2'd0, 8'h11);
        isu = 8'hA1; go(CmdShiftUp, 2'd1, 2'd0, 2'd0); do_ack();
        isd = 8'hB2; go(CmdShiftDown, 2'd1, 2'd0, 2'd0); do_ack();
        isr = 8'hC3; go(CmdShiftRight, 2'd1, 2'd0, 2'd0); do_ack();
        isl = 8'h22;
        go(CmdShiftLeft, 2'd0, 2'd0, 2'd0);
        check2("shl_done", sat_done, wrp_done, 1);
        check2("shl_osl", sat_osl, wrp_osl, 8'h11);
        check2("shl_osu", sat_osu, wrp_osu, 8'h07);
        check2("shl_osd", sat_osd, wrp_osd, 8'hA1);
        check2("shl_osr", sat_osr, wrp_osr, 8'hB2);
        check2("shl_bus", sat_bus, wrp_bus, 24'h00C322);
        do_ack();

        // Out-of-range image_sel targets image 0.
        load_img(2'd3, 8'h5A);
        check2("oor_bus", sat_bus, wrp_bus, 24'h00C35A);

        // 127*127 onto 0x7FFF: clamp vs wrap; a_sel=3 aliases image 0; ack in EXEC ignored.
        load_img(2'd0, 8'h7F);
        load_acc(16'h7FFF);
        go(CmdMac, 2'd0, 2'd3, 2'd0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check2("pos_e1_done", sat_done, wrp_done, 0);
        check2("pos_e1_busy", sat_busy, wrp_busy, 1);
        tick();
        check2("pos_done", sat_done, wrp_done, 1);
        check("sat_pos_acc", sat_acc, 16'h7FFF);
        check("wrp_pos_acc", wrp_acc, 16'hBF00);
        check2("pos_ovf", sat_ovf, wrp_ovf, 1);
        do_ack();
        load_acc(16'h8000);
        check2("ldacc_ovf_clr", sat_ovf, wrp_ovf, 0);

        // 127*-127 onto 0x8000: negative clamp vs wrap.
        load_img(2'd1, 8'h81);
        go(CmdMac, 2'd0, 2'd0, 2'd1);
        tick();
        tick();
        check("sat_neg_acc", sat_acc, 16'h8000);
        check("wrp_neg_acc", wrp_acc, 16'h40FF);
        check2("neg_ovf", sat_ovf, wrp_ovf, 1);
        do_ack();

        go(CmdClear, 2'd0, 2'd0, 2'd0);
        check2("clr_done", sat_done, wrp_done, 1);
        check2("clr_acc", sat_acc, wrp_acc, 0);
        check2("clr_ovf", sat_ovf, wrp_ovf, 0);
        check2("clr_bus", sat_bus, wrp_bus, 0);
        check2("clr_osl", sat_osl, wrp_osl, 0);
        check2("clr_osr", sat_osr, wrp_osr, 0);
        do_ack();

        // Reset one cycle after MAC accept abandons the MAC.
        load_acc(16'd100);
        load_img(2'd0, 8'h02);
        load_img(2'd1, 8'h03);
        go(CmdMac, 2'd0, 2'd0, 2'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check2("mrst_busy", sat_busy, wrp_busy, 0);
        check2("mrst_done", sat_done, wrp_done, 0);
        check2("mrst_acc", sat_acc, wrp_acc, 0);
        tick();
        tick();
        tick();
        check2("mrst_late_acc", sat_acc, wrp_acc, 0);
        check2("mrst_late_done", sat_done, wrp_done, 0);
        check2("mrst_late_busy", sat_busy, wrp_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pe_router_cell.md
PE_ROUTER_CELL -- requirements
Module: pe_router_cell

Interface
REQ-001 SHALL have parameter PRECISION, default 8: operand width, signed two's complement.
REQ-002 SHALL have parameter OUTPUT_PRECISION, default 32: accumulator width, at least 2*PRECISION.
REQ-003 SHALL have parameter NUM_IMAGES, default 2: number of operand registers, range 2..8; SEL_W = max(1, clog2(NUM_IMAGES)).
REQ-004 SHALL have parameter MAC_LATENCY, default 2: cycles from MAC accept to accumulator update, at least 1.
REQ-005 SHALL have parameter SATURATE, default 0: 1 = saturating accumulate, 0 = wrap.
REQ-006 SHALL have the following ports:
- CLK  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  command request; sampled only in IDLE.
- cmd  in  3  000 MAC, 001 shift_up, 010 shift_down, 011 shift_left, 100 shift_right, 101 load image, 110 load accumulator, 111 clear.
- image_sel  in  SEL_W  image register targeted by shift and load.
- a_sel, b_sel  in  SEL_W each  MAC operand image indices.
- isu, isd, isl, isr  in  PRECISION each  shift inputs from the neighbour.
- osu, osd, osl, osr  out  PRECISION each  registered shift outputs.
- load_data  in  PRECISION  image load value.
- acc_load  in  OUTPUT_PRECISION  accumulator load value.
- ack  in  1  consumer acknowledge of done.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  command complete; held until acknowledged.
- acc  out  OUTPUT_PRECISION  accumulator.
- overflow  out  1  sticky accumulate-overflow flag.
- image_bus  out  NUM_IMAGES*PRECISION  all image registers; image k occupies bits [k*PRECISION +: PRECISION].

Function
REQ-007 SHALL implement the states IDLE, EXEC and DONE.
REQ-008 SHALL accept a command on a rising edge with state IDLE and start=1; at that edge cmd, image_sel, a_sel, b_sel and the data inputs are captured.
REQ-009 SHALL complete non-MAC commands on the accept edge (register update at that edge), move to DONE and assert done from the next cycle (latency 1).
REQ-010 SHALL, for shift in direction X, set osX <= image[image_sel] and image[image_sel] <= isX at the same edge; the other three os* outputs hold.
REQ-011 SHALL implement load image as image[image_sel] <= load_data; load accumulator as acc <= acc_load and overflow <= 0; clear as all images, acc, overflow and all os* <= 0.
REQ-012 SHALL, for MAC, capture image[a_sel] and image[b_sel] at the accept edge, enter EXEC, and sign-extend the product to OUTPUT_PRECISION.
REQ-013 SHALL add that product to acc exactly MAC_LATENCY edges after the accept edge, then move to DONE.
REQ-014 SHALL, with SATURATE=1 and signed overflow, clamp acc to the most positive or most negative value; with SATURATE=0, wrap modulo 2^OUTPUT_PRECISION.
REQ-015 SHALL, in either mode, set overflow to 1 on signed overflow and keep it set until load accumulator, clear, or reset.
REQ-016 SHALL ignore start while busy; images, acc and all outputs hold until the next accepted command.
REQ-017 SHALL, in DONE with ack=1, return to IDLE at that edge with done deasserting; start at that same edge is ignored.
REQ-018 SHALL treat ack in IDLE or EXEC as having no effect.
REQ-019 SHALL treat image_sel, a_sel or b_sel >= NUM_IMAGES as index 0.
REQ-020 SHALL let image changes during EXEC not affect an in-flight MAC; no such change can occur, since commands are blocked while busy.

Reset
REQ-021 SHALL, on reset=1 at a rising edge, set state to IDLE and busy, done, overflow, acc, all images and all os* to 0.
REQ-022 SHALL let reset have priority over every command, abandoning an in-flight MAC without updating acc.

Structure
REQ-023 SHALL place the cmd encoding and the state enum in shared package pe_pkg.
REQ-024 SHALL implement the multiplier pipeline as sub-module pe_mac_pipe (params PRECISION, MAC_LATENCY; signed operands in, valid in, product and valid out).

Verification (PRECISION=8)
REQ-025 SHALL cover: load image0=0xFD, image1=7, acc_load=100, MAC a_sel=0, b_sel=1 -> done exactly MAC_LATENCY cycles after accept, acc=79, overflow=0.
REQ-026 SHALL cover: image0=0x11, isl=0x22, shift_left image_sel=0 -> osl=0x11, image0=0x22, done the next cycle, osu/osd/osr unchanged.
REQ-027 SHALL cover: OUTPUT_PRECISION=16, SATURATE=1, acc=0x7FFF, MAC 127*127 -> acc=0x7FFF, overflow=1; same with SATURATE=0 -> acc=0xBF00, overflow=1.
REQ-028 SHALL cover: start pulsed during EXEC and DONE -> ignored; hold ack low 5 cycles -> done stays 1; ack and start together -> IDLE, second command not executed.
REQ-029 SHALL cover: reset asserted one cycle after MAC accept -> next cycle busy=0, done=0, acc=0, no later acc update.
